fifo_sp_ctrl: RTL and testbench
===============================

// Module: fifo_sp_ctrl
// PURPOSE
//  Turns the single-port RAM (one access per cycle, registered read) into a true FIFO.
//  Owns the write pointer, read pointer and occupancy, and drives the RAM port.
//  Arbitrates between writes from the push side and prefetch reads into a one-entry output register.
//  Both sides use valid/ready handshakes. Sits between the producer/consumer logic and the RAM instance.
// PARAMETERS
//  ADDR_WIDTH  8    RAM address width
//  DATA_WIDTH  10   word width
//  MEM_SIZE    256  RAM depth; must satisfy 2 <= MEM_SIZE <= 2**ADDR_WIDTH (non-power-of-2 allowed)
// PORTS
//  CLK         in   1           clock; all state updates on posedge CLK
//  RST         in   1           synchronous, active-high reset
//  PUSH_VALID  in   1           producer has a word
//  PUSH_DATA   in   DATA_WIDTH  word to enqueue
//  PUSH_READY  out  1           word accepted this cycle when PUSH_VALID & PUSH_READY
//  POP_VALID   out  1           output register holds the head word
//  POP_DATA    out  DATA_WIDTH  head word
//  POP_READY   in   1           consumer takes the word when POP_VALID & POP_READY
//  COUNT       out  ADDR_WIDTH+1  words held = ram_cnt + POP_VALID
//  FULL        out  1           ram_cnt == MEM_SIZE
//  EMPTY       out  1           COUNT == 0
//  RAM_ADDR    out  ADDR_WIDTH  RAM address
//  RAM_DIN     out  DATA_WIDTH  RAM write data (= PUSH_DATA)
//  RAM_EN      out  1           RAM enable
//  RAM_WE      out  1           RAM write enable
//  RAM_DOUT    in   DATA_WIDTH  RAM read data; valid only while RAM_EN=1 & RAM_WE=0
// BEHAVIOUR
//  Reset values (cycle after RST=1):
//   - wr_ptr, rd_ptr, ram_cnt, POP_VALID, POP_DATA, COUNT = 0; EMPTY = 1; FULL = 0
//   - state = IDLE; PRI = write
//   - while RST=1: RAM_EN = 0, PUSH_READY = 0
//  RST has priority over all other events. RAM contents are not cleared.
//  FSM states: IDLE, RD_CAP.
//   read_need = (ram_cnt != 0) & (!POP_VALID | POP_READY)
//   PUSH_READY = IDLE & !FULL & !(read_need & PRI==read); PUSH_READY never depends on PUSH_VALID.
//   grant_wr = PUSH_VALID & PUSH_READY
//   grant_rd = IDLE & read_need & !grant_wr
//  Write (1 cycle, stays IDLE):
//   - drive RAM_EN=1, RAM_WE=1, RAM_ADDR=wr_ptr
//   - wr_ptr++, ram_cnt++; PRI <= read
//  Read issue (IDLE -> RD_CAP): drive RAM_EN=1, RAM_WE=0, RAM_ADDR=rd_ptr.
//  RD_CAP (always returns to IDLE):
//   - hold RAM_EN=1, RAM_WE=0, RAM_ADDR=rd_ptr
//   - POP_DATA <= RAM_DOUT, POP_VALID <= 1
//   - rd_ptr++, ram_cnt--; PRI <= write
//   - PUSH_READY = 0
//  Other cycles: RAM_EN=0, RAM_WE=0.
//  POP_VALID clears on the handshake unless RD_CAP refills it in the same cycle.
//  Pointer wrap: MEM_SIZE-1 -> 0, explicit compare (no modulo by width).
//  Simultaneous push and pop: both proceed; COUNT changes by net +1, 0 or -1.
//  Latency: push handshake at cycle t -> POP_VALID=1 at t+3 when the FIFO was empty.
//  Capacity is MEM_SIZE+1 words (RAM + output register).
//  Pop while EMPTY: no RAM access, POP_VALID stays 0. Push while FULL: PUSH_READY=0, no write.
//  Reset mid-read (RST in RD_CAP): capture discarded; state -> IDLE; all reset values apply.
//  PRI alternates grants under contention: no starvation; a write waits at most 2 cycles.
// STRUCTURE
//  Package fifo_ctrl_pkg:
//   - localparams ST_IDLE=1'b0, ST_RD_CAP=1'b1
//   - PRI_WR=1'b0, PRI_RD=1'b1
//  Sub-module fifo_ptr: ADDR_WIDTH-bit pointer register with increment enable, wrap at MEM_SIZE-1
//  and synchronous reset; instantiated for wr_ptr and rd_ptr.
//  The remaining logic (FSM, counter, output register) lives in fifo_sp_ctrl.
//  The bench instantiates the RAM alongside; RAM RST is tied low.
// TESTING
//  1 Reset, push 0x001,0x002,0x003 with POP_READY=0
//    -> RAM writes at addr 0,1,2; POP_VALID=1, POP_DATA=0x001 three cycles after the first push; COUNT=3
//  2 MEM_SIZE=4, POP_READY=0, push 6 words
//    -> first 5 accepted; 6th sees PUSH_READY=0, FULL=1, COUNT=5
//  3 MEM_SIZE=3, ADDR_WIDTH=2, stream 10 words through
//    -> RAM_ADDR write sequence 0,1,2,0,1,...; output order preserved; EMPTY=1 at end
//  4 FIFO holds 2; PUSH_VALID=1 and POP_READY=1 held
//    -> grants alternate write, read(2 cycles), write...; no lost or duplicated words
//  5 Assert RST during RD_CAP
//    -> next cycle RAM_EN=0, POP_VALID=0, COUNT=0, EMPTY=1; PUSH_READY=1 once RST=0
//  6 EMPTY, POP_READY=1 for 5 cycles
//    -> RAM_EN stays 0, POP_VALID stays 0, COUNT=0

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared encodings for the single-port FIFO controller.
// FSM state and arbitration-priority codes.
package fifo_ctrl_pkg;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_RD_CAP = 1'b1;

  localparam logic PRI_WR = 1'b0;
  localparam logic PRI_RD = 1'b1;

endpackage

// File: rtl/fifo_ptr.sv
// Circular RAM pointer with increment enable.
// Wraps at MEM_SIZE-1, so non-power-of-2 depths work.
module fifo_ptr #(
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_SIZE   = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] ptr
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_SIZE - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_sp_ctrl.sv
// FIFO controller over a single-port RAM with registered read.
// Writes and head prefetches share the port under alternating priority.
module fifo_sp_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 10,
  parameter int MEM_SIZE   = 256
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PUSH_VALID,
  input  logic [DATA_WIDTH-1:0] PUSH_DATA,
  output logic                  PUSH_READY,
  output logic                  POP_VALID,
  output logic [DATA_WIDTH-1:0] POP_DATA,
  input  logic                  POP_READY,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  output logic [DATA_WIDTH-1:0] RAM_DIN,
  output logic                  RAM_EN,
  output logic                  RAM_WE,
  input  logic [DATA_WIDTH-1:0] RAM_DOUT
);

  localparam logic [ADDR_WIDTH:0] CNT_MAX =
    (ADDR_WIDTH + 1)'(MEM_SIZE);

  logic                  state;
  logic                  state_nx;
  logic                  pri;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic                  pop_valid_q;
  logic [DATA_WIDTH-1:0] pop_data_q;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  read_need;
  logic                  push_ready;
  logic                  grant_wr;
  logic                  grant_rd;
  logic                  cap;

  assign FULL      = (ram_cnt == CNT_MAX);
  assign read_need = (ram_cnt != '0) &&
                     (!pop_valid_q || POP_READY);
  assign cap       = !RST && (state == ST_RD_CAP);

  always_comb begin
    state_nx   = state;
    push_ready = 1'b0;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    RAM_EN     = 1'b0;
    RAM_WE     = 1'b0;
    RAM_ADDR   = rd_ptr;
    if (!RST) begin
      unique case (state)
        ST_IDLE: begin
          push_ready = !FULL &&
                       !(read_need && pri == PRI_RD);
          grant_wr   = PUSH_VALID && push_ready;
          grant_rd   = read_need && !grant_wr;
          if (grant_wr) begin
            RAM_EN   = 1'b1;
            RAM_WE   = 1'b1;
            RAM_ADDR = wr_ptr;
          end else if (grant_rd) begin
            RAM_EN   = 1'b1;
            state_nx = ST_RD_CAP;
          end
        end
        ST_RD_CAP: begin
          RAM_EN   = 1'b1;
          state_nx = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      pri         <= PRI_WR;
      ram_cnt     <= '0;
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
    end else begin
      state <= state_nx;
      if (grant_wr) pri <= PRI_RD;
      if (cap)      pri <= PRI_WR;
      // a write and a capture never share a cycle
      if (grant_wr)  ram_cnt <= ram_cnt + 1'b1;
      else if (cap)  ram_cnt <= ram_cnt - 1'b1;
      if (cap) begin
        pop_valid_q <= 1'b1;
        pop_data_q  <= RAM_DOUT;
      end else if (pop_valid_q && POP_READY) begin
        pop_valid_q <= 1'b0;
      end
    end
  end

  fifo_ptr #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .MEM_SIZE  (MEM_SIZE)
  ) u_wr_ptr (
    .clk(CLK),
    .rst(RST),
    .inc(grant_wr),
    .ptr(wr_ptr)
  );

  fifo_ptr #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .MEM_SIZE  (MEM_SIZE)
  ) u_rd_ptr (
    .clk(CLK),
    .rst(RST),
    .inc(cap),
    .ptr(rd_ptr)
  );

  assign PUSH_READY = push_ready;
  assign POP_VALID  = pop_valid_q;
  assign POP_DATA   = pop_data_q;
  assign COUNT      = ram_cnt + (ADDR_WIDTH + 1)'(pop_valid_q);
  assign EMPTY      = (COUNT == '0);
  assign RAM_DIN    = PUSH_DATA;

endmodule

// File: tb/tb_fifo_sp_ctrl.sv
// Bench for fifo_sp_ctrl with a registered-read RAM model.
// Scoreboard queue fed on push handshakes, drained on pop handshakes.
module tb_fifo_sp_ctrl;

  localparam int AW = 2;
  localparam int DW = 10;
  localparam int MS = 3;

  logic          clk;
  logic          rst;
  logic          push_valid;
  logic [DW-1:0] push_data;
  logic          push_ready;
  logic          pop_valid;
  logic [DW-1:0] pop_data;
  logic          pop_ready;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_en;
  logic          ram_we;
  logic [DW-1:0] ram_dout;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mcount = 0;
  int wr_n = 0;
  int wait_n = 0;
  int t_push = 0;
  int t_pop = 0;
  bit armed = 0;
  logic [DW-1:0] q [$];

  fifo_sp_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MEM_SIZE  (MS)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .PUSH_VALID(push_valid),
    .PUSH_DATA (push_data),
    .PUSH_READY(push_ready),
    .POP_VALID (pop_valid),
    .POP_DATA  (pop_data),
    .POP_READY (pop_ready),
    .COUNT     (count),
    .FULL      (full),
    .EMPTY     (empty),
    .RAM_ADDR  (ram_addr),
    .RAM_DIN   (ram_din),
    .RAM_EN    (ram_en),
    .RAM_WE    (ram_we),
    .RAM_DOUT  (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        ram_dout <= mem[ram_addr];
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  // reference model: occupancy, order, write address sequence
  always @(negedge clk) begin
    if (armed) begin
      chk("count", 32'(count), mcount);
      chk("empty", 32'(empty), 32'(mcount == 0));
      chk("full", 32'(full),
          32'((mcount - int'(pop_valid)) == MS));
      if (rst) begin
        chk("rst_ram_en", 32'(ram_en), 0);
        chk("rst_push_ready", 32'(push_ready), 0);
        q.delete();
        mcount = 0;
        wr_n = 0;
        wait_n = 0;
      end else begin
        chk("wr_strobe", 32'(ram_en & ram_we),
            32'(push_valid & push_ready));
        chk("no_overflow",
            32'(push_ready && mcount == MS + 1), 0);
        if (push_valid && !push_ready && !full) begin
          wait_n++;
          chk("push_wait", 32'(wait_n <= 2), 1);
        end else begin
          wait_n = 0;
        end
        if (push_valid && push_ready) begin
          chk("wr_addr", 32'(ram_addr), wr_n % MS);
          chk("wr_din", 32'(ram_din), 32'(push_data));
          wr_n++;
          q.push_back(push_data);
          mcount++;
        end
        if (pop_valid && pop_ready) begin
          chk("pop_avail", 32'(q.size() != 0), 1);
          if (q.size() != 0)
            chk("pop_data", 32'(pop_data),
                32'(q.pop_front()));
          mcount--;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    push_valid = 1'b0;
    pop_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push_word(input logic [DW-1:0] d,
                           output bit ok);
    ok = 1'b0;
    push_valid = 1'b1;
    push_data = d;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (push_valid && push_ready) begin
        ok = 1'b1;
        t_push = cyc;
      end
      tick();
    end
    push_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    push_valid = 1'b0;
    pop_ready = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      done = empty;
      tick();
    end
    chk("drain_empty", 32'(done), 1);
  endtask

  initial begin
    bit ok;
    bit seen;
    bit w;
    bit r;
    int acc;
    int nw;
    int np;
    int pv;
    int pr;
    rst = 1'b1;
    push_valid = 1'b0;
    push_data = '0;
    pop_ready = 1'b0;
    tick();
    armed = 1'b1;
    do_reset();

    // head appears three cycles after the first push
    push_word(10'h001, ok);
    chk("t1_push1", 32'(ok), 1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (pop_valid) begin
        seen = 1'b1;
        t_pop = cyc;
      end else begin
        tick();
      end
    end
    chk("t1_seen", 32'(seen), 1);
    if (seen) begin
      chk("t1_latency", 32'(t_pop - t_push), 3);
      chk("t1_head", 32'(pop_data), 32'h001);
      tick();
    end
    push_word(10'h002, ok);
    chk("t1_push2", 32'(ok), 1);
    push_word(10'h003, ok);
    chk("t1_push3", 32'(ok), 1);
    @(negedge clk);
    chk("t1_count", 32'(count), 3);
    tick();

    // capacity is MEM_SIZE+1
    do_reset();
    acc = 0;
    for (int i = 0; i < MS + 2; i++) begin
      push_word(10'(12'h200 + i), ok);
      if (ok) acc++;
    end
    @(negedge clk);
    chk("t2_accepted", acc, MS + 1);
    chk("t2_full", 32'(full), 1);
    chk("t2_push_ready", 32'(push_ready), 0);
    chk("t2_count", 32'(count), MS + 1);
    tick();

    // streaming across pointer wrap
    do_reset();
    pop_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_word(10'(12'h100 + i), ok);
      chk("t3_push", 32'(ok), 1);
    end
    drain();

    // contention: alternation with both sides busy
    do_reset();
    push_word(10'h020, ok);
    push_word(10'h021, ok);
    pop_ready = 1'b1;
    push_valid = 1'b1;
    push_data = 10'h030;
    nw = 0;
    np = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      w = push_valid && push_ready;
      r = pop_valid && pop_ready;
      tick();
      if (w) begin
        nw++;
        push_data = 10'($urandom);
      end
      if (r) np++;
    end
    chk("t4_writes", 32'(nw >= 3), 1);
    chk("t4_pops", 32'(np >= 3), 1);
    drain();

    // reset while a capture is in flight
    do_reset();
    push_word(10'h055, ok);
    @(negedge clk);
    chk("t5_issue_en", 32'(ram_en), 1);
    chk("t5_issue_we", 32'(ram_we), 0);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("t5_ram_en", 32'(ram_en), 0);
    chk("t5_pop_valid", 32'(pop_valid), 0);
    chk("t5_count", 32'(count), 0);
    chk("t5_empty", 32'(empty), 1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_push_ready", 32'(push_ready), 1);
    tick();

    // pops against an empty FIFO do nothing
    pop_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_ram_en", 32'(ram_en), 0);
      chk("t6_pop_valid", 32'(pop_valid), 0);
      chk("t6_count", 32'(count), 0);
      tick();
    end

    // random traffic in phases of varying pressure
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: begin pv = 80; pr = 30; end
        1: begin pv = 30; pr = 80; end
        2: begin pv = 90; pr = 10; end
        default: begin pv = 60; pr = 60; end
      endcase
      for (int i = 0; i < 100; i++) begin
        push_valid = ($urandom_range(99) < pv);
        pop_ready = ($urandom_range(99) < pr);
        push_data = 10'($urandom);
        tick();
      end
    end
    drain();
    chk("sb_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
